aes_encrypt_core: RTL and testbench
===================================

Name: aes_encrypt_core

Overview:
- Iterative AES-128 encryption engine: forward cipher counterpart to the decryption datapath (SubBytes, ShiftRows, MixColumns, AddRoundKey).
- Executes one round per clock with on-the-fly key expansion.
- Valid/ready handshake on input and output.
- Sits between the host block buffer and the link/output stage; the decrypt path consumes its ciphertext.

Parameters:
- OUT_ZERO_IDLE, 1, when 1 ct_out is driven to 0 whenever out_valid=0; when 0 ct_out shows the internal state register.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  pt_in/key_in valid.
- in_ready  out  1  core can accept a block.
- pt_in  in  128  plaintext; byte 0 at [127:120], column-major state (byte n = row n%4, column n/4).
- key_in  in  128  cipher key, same byte order.
- out_valid  out  1  ct_out valid.
- out_ready  in  1  downstream accepts ct_out.
- ct_out  out  128  ciphertext, same byte order.
- busy  out  1  high while rounds are in progress.

Behaviour:
- Reset (async assert, sync release): state IDLE; in_ready=1, out_valid=0, busy=0, ct_out=0, internal state/round-key/round-counter registers=0.
- FSM states IDLE, BUSY, DONE.
  - IDLE: in_ready=1. Accept occurs on the edge where in_valid&in_ready.
    - On accept: state_reg<=pt_in^key_in, rk_reg<=key_in, rnd<=1, go BUSY.
    - Inputs are sampled only on that edge; later changes are ignored.
  - BUSY: in_ready=0, busy=1. Each edge computes round rnd:
    - rk_next = KeyExpand(rk_reg, rcon[rnd]), where rcon = 01,02,04,08,10,20,40,80,1b,36 for rnd 1..10.
    - KeyExpand: w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon,00,00,00}; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'. w0 is [127:96].
    - rnd 1..9: state_reg <= MixColumns(ShiftRows(SubBytes(state_reg))) ^ rk_next.
    - rnd 10: MixColumns is omitted; go DONE.
    - Otherwise rk_reg <= rk_next and rnd <= rnd+1.
  - DONE: out_valid=1, ct_out=state_reg held stable; in_ready=0.
    - out_ready=1 on an edge: return to IDLE, out_valid drops.
    - out_ready may be high before out_valid. Handshake completes on the first edge where both are 1, i.e. the cycle DONE is entered plus one edge.
- Latency: accept edge T; out_valid=1 in the cycle after edge T+10. Minimum spacing between accepts is 12 cycles with out_ready tied high.
- ShiftRows (forward) per output byte:
  - row 1: out1=in5, out5=in9, out9=in13, out13=in1.
  - row 2: out2=in10, out6=in14, out10=in2, out14=in6.
  - row 3: out3=in15, out7=in3, out11=in7, out15=in11.
  - Row 0 unchanged.
- MixColumns per column [a0..a3]: b0=2a0^3a1^a2^a3, rotating similarly. xtime(x) = (x<<1) ^ (x[7] ? 8'h1b : 0).
- S-box: forward AES S-box, either a 256-entry table or GF(2^8) inverse plus affine transform. It must match FIPS-197 for all 256 inputs. 20 instances: 16 state, 4 key.
- in_valid while not in IDLE: ignored, no accept, no state change.
- Reset mid-operation clears everything immediately; any partial result is lost and no out_valid is generated.
- rnd is never outside 1..10 in BUSY. An illegal FSM encoding recovers to IDLE.
- OUT_ZERO_IDLE=1: ct_out=0 whenever out_valid=0.

Test Plan:
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> ct_out 3925841d02dc09fbdc118597196a0b32, out_valid rises exactly 10 edges after the accept edge.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a. Feeding this result into the decrypt path returns the plaintext.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> ct_out stable, in_ready=0, new in_valid ignored. Raise out_ready -> one transfer, then in_ready=1 the next cycle.
- Back-to-back: in_valid held high with B then C1 vectors, out_ready=1 -> two correct ciphertexts, accepts 12 cycles apart. Changing pt_in during BUSY has no effect.
- Reset: assert rst_n=0 at round 5 -> outputs go immediately to reset values, no out_valid. The next block after release encrypts correctly.
- Random: 1000 random key/pt pairs vs a software AES-128 model, with random out_ready stalls -> all ciphertexts match, no lost or duplicated transfers.

Source files
------------

// File: rtl/aes_encrypt_core.sv
// rtl/aes_encrypt_core.sv - iterative AES-128 encryption core, one round per clock
// with on-the-fly key expansion and valid/ready handshakes on both sides.
module aes_encrypt_core #(
  parameter bit OUT_ZERO_IDLE = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] pt_in,
  input  logic [127:0] key_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ct_out,
  output logic         busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } fsm_t;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[~{x, 3'b000} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  fsm_t         fsm;
  logic [127:0] state_reg;
  logic [127:0] rk_reg;
  logic [3:0]   rnd;
  logic         in_ready_r;
  logic         out_valid_r;
  logic         busy_r;

  logic [7:0]   sb [16];
  logic [7:0]   sr [16];
  logic [7:0]   mc [16];
  logic [127:0] round_out;
  logic [127:0] rk_next;
  logic [31:0]  rot_w3;
  logic [31:0]  sub_w3;
  logic [31:0]  w0n, w1n, w2n, w3n;
  logic [7:0]   rcon;

  always_comb begin
    rcon = 8'h00;
    case (rnd)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign rot_w3  = {rk_reg[23:0], rk_reg[31:24]};
  assign sub_w3  = {sbox(rot_w3[31:24]), sbox(rot_w3[23:16]), sbox(rot_w3[15:8]), sbox(rot_w3[7:0])};
  assign w0n     = rk_reg[127:96] ^ sub_w3 ^ {rcon, 24'h000000};
  assign w1n     = rk_reg[95:64] ^ w0n;
  assign w2n     = rk_reg[63:32] ^ w1n;
  assign w3n     = rk_reg[31:0] ^ w2n;
  assign rk_next = {w0n, w1n, w2n, w3n};

  // Byte n sits at row n%4, column n/4; ShiftRows pulls row r from column (c+r)%4.
  for (genvar n = 0; n < 16; n++) begin : g_byte
    assign sb[n] = sbox(state_reg[127-8*n -: 8]);
    assign sr[n] = sb[(n % 4) + 4 * (((n / 4) + (n % 4)) % 4)];
    assign round_out[127-8*n -: 8] = ((rnd == 4'd10) ? sr[n] : mc[n]) ^ rk_next[127-8*n -: 8];
  end

  for (genvar c = 0; c < 4; c++) begin : g_mix
    assign mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
    assign mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
    assign mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
    assign mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm         <= S_IDLE;
      state_reg   <= '0;
      rk_reg      <= '0;
      rnd         <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (fsm)
        S_IDLE: begin
          if (in_valid) begin
            state_reg  <= pt_in ^ key_in;
            rk_reg     <= key_in;
            rnd        <= 4'd1;
            fsm        <= S_BUSY;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end
        end
        S_BUSY: begin
          state_reg <= round_out;
          if (rnd == 4'd10) begin
            fsm         <= S_DONE;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b1;
          end else begin
            rk_reg <= rk_next;
            rnd    <= rnd + 4'd1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            fsm         <= S_IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          fsm         <= S_IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign ct_out    = (OUT_ZERO_IDLE && !out_valid_r) ? 128'd0 : state_reg;

endmodule

// File: tb/tb_aes_encrypt_core.sv
// tb/tb_aes_encrypt_core.sv - self-checking bench for aes_encrypt_core against a
// software AES-128 model and a cycle-level handshake model.
module tb_aes_encrypt_core;

  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] pt_in = '0;
  logic [127:0] key_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] ct_out;
  logic         busy;

  aes_encrypt_core #(.OUT_ZERO_IDLE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .pt_in(pt_in), .key_in(key_in), .out_valid(out_valid), .out_ready(out_ready),
    .ct_out(ct_out), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int nblk = 0;
  int d_xfer = 0;
  int m_acc = 0;
  int m_xfer = 0;
  int m_phase = 0;
  int m_cnt = 0;
  logic [127:0] m_ct = '0;
  logic [127:0] rx[$];
  logic [7:0]   sb_t[256];
  bit           rand_ready = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0] w [44];
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [7:0]  rc;
    logic [31:0] tmp;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb_t[tmp[23:16]], sb_t[tmp[15:8]], sb_t[tmp[7:0]], sb_t[tmp[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int n = 0; n < 16; n++) s[n] = pt[127-8*n -: 8] ^ key[127-8*n -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int n = 0; n < 16; n++) s[n] = sb_t[s[n]];
      for (int n = 0; n < 16; n++) t[n] = s[(n % 4) + 4 * (((n / 4) + (n % 4)) % 4)];
      for (int c = 0; c < 4; c++)
        for (int i = 0; i < 4; i++)
          s[4*c+i] = (r == 10) ? t[4*c+i] :
                     gmul(t[4*c+i], 8'h02) ^ gmul(t[4*c+(i+1)%4], 8'h03) ^ t[4*c+(i+2)%4] ^ t[4*c+(i+3)%4];
      for (int n = 0; n < 16; n++) s[n] ^= w[4*r + n/4][31-8*(n%4) -: 8];
    end
    for (int n = 0; n < 16; n++) res[127-8*n -: 8] = s[n];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model: idle -> 10 cycles busy -> done until out_ready.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_cnt   = 0;
      m_ct    = '0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          m_ct = aes_ref(pt_in, key_in);
          m_phase = 1;
          m_cnt = 10;
          m_acc++;
        end
        1: begin
          m_cnt--;
          if (m_cnt == 0) m_phase = 2;
        end
        default: if (out_ready) begin
          m_phase = 0;
          m_xfer++;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    check("in_ready", in_ready, m_phase == 0);
    check("busy", busy, m_phase == 1);
    check("out_valid", out_valid, m_phase == 2);
    check("ct_out", ct_out, (m_phase == 2) ? m_ct : 128'd0);
    if (out_valid && out_ready) begin
      d_xfer++;
      rx.push_back(ct_out);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic run_block(input logic [127:0] p, input logic [127:0] k);
    int a0;
    a0 = m_acc;
    nblk++;
    in_valid = 1'b1;
    pt_in = p;
    key_in = k;
    for (int i = 0; i < 300 && m_acc == a0; i++) tick();
    check("accept_timeout", m_acc != a0, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && m_phase != 0; i++) tick();
    check("idle_timeout", m_phase == 0, 1);
  endtask

  task automatic wait_out_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    #900000;
    check("watchdog", 0, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    logic [7:0] inv;
    int lat, t1, t2, x0;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sb_t[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
                {inv[3:0], inv[7:4]} ^ 8'h63;
    end
    check("model_sbox_00", sb_t[8'h00], 8'h63);
    check("model_sbox_53", sb_t[8'h53], 8'hed);
    check("model_sbox_ff", sb_t[8'hff], 8'h16);
    check("model_ct_b", aes_ref(PT_B, KEY_B), CT_B);
    check("model_ct_c1", aes_ref(PT_C1, KEY_C1), CT_C1);

    repeat (3) tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ct_out", ct_out, 0);
    rst_n = 1'b1;
    tick();

    run_block(PT_B, KEY_B);
    wait_out_valid(lat);
    check("latency_b", lat, 10);
    check("ct_b", ct_out, CT_B);
    wait_idle();

    out_ready = 1'b0;
    run_block(PT_C1, KEY_C1);
    for (int i = 0; i < 40 && m_phase != 2; i++) tick();
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      pt_in = rand128();
      key_in = rand128();
      tick();
      check("bp_ct", ct_out, CT_C1);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
    end
    x0 = d_xfer;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_out_valid", out_valid, 0);
    repeat (3) tick();
    check("bp_one_xfer", d_xfer - x0, 1);

    run_block(PT_B, KEY_B);
    t1 = cyc;
    run_block(PT_C1, KEY_C1);
    t2 = cyc;
    pt_in = rand128();
    check("b2b_spacing", t2 - t1, 12);
    wait_idle();
    check("b2b_rx_count", rx.size() >= 2, 1);
    if (rx.size() >= 2) begin
      check("b2b_ct_b", rx[rx.size()-2], CT_B);
      check("b2b_ct_c1", rx[rx.size()-1], CT_C1);
    end

    run_block(PT_B, KEY_B);
    repeat (4) tick();
    #1 rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_ct_out", ct_out, 0);
    tick();
    tick();
    rst_n = 1'b1;
    x0 = d_xfer;
    repeat (15) tick();
    check("midrst_no_xfer", d_xfer - x0, 0);
    run_block(PT_C1, KEY_C1);
    wait_out_valid(lat);
    check("post_rst_latency", lat, 10);
    check("post_rst_ct", ct_out, CT_C1);
    wait_idle();

    rand_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      run_block(rand128(), rand128());
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    repeat (2) tick();

    check("dut_xfer_count", d_xfer, nblk - 1);
    check("model_xfer_count", m_xfer, nblk - 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
